// File: rtl/dbg_arb_pkg.sv
// Shared types for the debug-memory arbiter.
// Response owner encoding and default stall-warning threshold.
package dbg_arb_pkg;

    typedef enum logic {
        OWNER_DEV   = 1'b0,
        OWNER_INSTR = 1'b1
    } arb_owner_e;

    localparam int unsigned StallWarnDefault = 16;

endpackage

// File: rtl/dbg_arb_stall_mon.sv
// Saturating consecutive-stall counter with a registered warning flag.
// The flag is computed from the next count so it rises with the count.
module dbg_arb_stall_mon #(
    parameter int unsigned CntWidth = 8,
    parameter int unsigned WarnThr  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                warn_o
);

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] Thr    = CntWidth'(WarnThr);

    logic [CntWidth-1:0] cnt_d;

    // Next count: clear when not stalled, hold at all ones when saturated.
    always_comb begin
        cnt_d = '0;
        if (stall_i) begin
            cnt_d = (cnt_o == CntMax) ? cnt_o : cnt_o + CntWidth'(1);
        end
    end

    // Count and warning registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_o  <= '0;
            warn_o <= 1'b0;
        end else begin
            cnt_o  <= cnt_d;
            warn_o <= (cnt_d >= Thr);
        end
    end

endmodule

// File: rtl/dbg_mem_arbiter.sv
// Fixed-priority arbiter sharing the debug-module slave memory between
// core fetch and the system-bus device port; device always wins.
module dbg_mem_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned StallCntWidth = 8,
    parameter int unsigned StallWarn     = StallWarnDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     instr_req_i,
    input  logic [AddrWidth-1:0]     instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [DataWidth-1:0]     instr_rdata_o,
    input  logic                     dev_req_i,
    input  logic [AddrWidth-1:0]     dev_addr_i,
    input  logic                     dev_we_i,
    input  logic [DataWidth/8-1:0]   dev_be_i,
    input  logic [DataWidth-1:0]     dev_wdata_i,
    output logic                     dev_rvalid_o,
    output logic [DataWidth-1:0]     dev_rdata_o,
    output logic                     slv_req_o,
    output logic                     slv_we_o,
    output logic [AddrWidth-1:0]     slv_addr_o,
    output logic [DataWidth/8-1:0]   slv_be_o,
    output logic [DataWidth-1:0]     slv_wdata_o,
    input  logic [DataWidth-1:0]     slv_rdata_i,
    output logic [StallCntWidth-1:0] stall_cnt_o,
    output logic                     stall_warn_o
);

    arb_owner_e winner;
    arb_owner_e resp_owner_q;
    logic       resp_valid_q;

    assign instr_gnt_o = instr_req_i & ~dev_req_i & rst_ni;
    assign slv_req_o   = (dev_req_i & rst_ni) | instr_gnt_o;
    assign winner      = dev_req_i ? OWNER_DEV : OWNER_INSTR;

    // Slave mux: device fields when it requests, else a full-word fetch read.
    always_comb begin
        slv_addr_o  = instr_addr_i;
        slv_we_o    = 1'b0;
        slv_be_o    = '1;
        slv_wdata_o = '0;
        if (dev_req_i) begin
            slv_addr_o  = dev_addr_i;
            slv_we_o    = dev_we_i;
            slv_be_o    = dev_be_i;
            slv_wdata_o = dev_wdata_i;
        end
    end

    // Remember who owns the response arriving next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWNER_DEV;
        end else begin
            resp_valid_q <= slv_req_o;
            resp_owner_q <= winner;
        end
    end

    assign instr_rvalid_o = resp_valid_q & (resp_owner_q == OWNER_INSTR);
    assign dev_rvalid_o   = resp_valid_q & (resp_owner_q == OWNER_DEV);
    assign instr_rdata_o  = slv_rdata_i;
    assign dev_rdata_o    = slv_rdata_i;

    dbg_arb_stall_mon #(
        .CntWidth (StallCntWidth),
        .WarnThr  (StallWarn)
    ) u_stall_mon (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_i (instr_req_i & ~instr_gnt_o),
        .cnt_o   (stall_cnt_o),
        .warn_o  (stall_warn_o)
    );

`ifndef SYNTHESIS
    a_no_gnt_on_dev: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_gnt_o && dev_req_i));
    a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_o && dev_rvalid_o));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)));
`endif

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Directed bench for dbg_mem_arbiter with a response scoreboard.
// A behavioural slave returns an address-derived word one cycle later.
module tb_dbg_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        dev_req_i = 1'b0;
    logic [31:0] dev_addr_i = '0;
    logic        dev_we_i = 1'b0;
    logic [3:0]  dev_be_i = '0;
    logic [31:0] dev_wdata_i = '0;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        slv_req_o;
    logic        slv_we_o;
    logic [31:0] slv_addr_o;
    logic [3:0]  slv_be_o;
    logic [31:0] slv_wdata_o;
    logic [31:0] slv_rdata_i = '0;
    logic [7:0]  stall_cnt_o;
    logic        stall_warn_o;

    typedef struct {
        logic        instr;
        logic [31:0] data;
    } resp_t;

    resp_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    int m_cnt = 0;
    logic m_warn = 1'b0;

    dbg_mem_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .dev_req_i      (dev_req_i),
        .dev_addr_i     (dev_addr_i),
        .dev_we_i       (dev_we_i),
        .dev_be_i       (dev_be_i),
        .dev_wdata_i    (dev_wdata_i),
        .dev_rvalid_o   (dev_rvalid_o),
        .dev_rdata_o    (dev_rdata_o),
        .slv_req_o      (slv_req_o),
        .slv_we_o       (slv_we_o),
        .slv_addr_o     (slv_addr_o),
        .slv_be_o       (slv_be_o),
        .slv_wdata_o    (slv_wdata_o),
        .slv_rdata_i    (slv_rdata_i),
        .stall_cnt_o    (stall_cnt_o),
        .stall_warn_o   (stall_warn_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h1a11_0800) return 32'h0010_0073;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk_i) begin
        slv_rdata_i <= slv_req_o ? mem_fn(slv_addr_o) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic check_resp();
        resp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, e.instr});
            chk("dev_rvalid", {31'b0, dev_rvalid_o}, {31'b0, ~e.instr});
            if (e.instr) chk("instr_rdata", instr_rdata_o, e.data);
            else chk("dev_rdata", dev_rdata_o, e.data);
        end else begin
            chk("no_rvalid", {30'b0, instr_rvalid_o, dev_rvalid_o}, 32'h0);
        end
    endtask

    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] da);
        logic eg;
        @(posedge clk_i);
        #1;
        instr_req_i = ir;
        instr_addr_i = ia;
        dev_req_i = dr;
        dev_we_i = dw;
        dev_be_i = be;
        dev_wdata_i = wd;
        dev_addr_i = da;
        eg = ir & ~dr & rst_ni;
        @(negedge clk_i);
        check_resp();
        chk("stall_cnt", {24'b0, stall_cnt_o}, m_cnt);
        chk("stall_warn", {31'b0, stall_warn_o}, {31'b0, m_warn});
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, eg});
        chk("slv_req", {31'b0, slv_req_o}, {31'b0, (dr & rst_ni) | eg});
        if (rst_ni && dr) begin
            chk("slv_addr_d", slv_addr_o, da);
            chk("slv_we_d", {31'b0, slv_we_o}, {31'b0, dw});
            chk("slv_be_d", {28'b0, slv_be_o}, {28'b0, be});
            chk("slv_wdata_d", slv_wdata_o, wd);
            q.push_back('{instr: 1'b0, data: mem_fn(da)});
        end else if (eg) begin
            chk("slv_addr_i", slv_addr_o, ia);
            chk("slv_we_i", {31'b0, slv_we_o}, 32'h0);
            chk("slv_be_i", {28'b0, slv_be_o}, 32'hf);
            chk("slv_wdata_i", slv_wdata_o, 32'h0);
            q.push_back('{instr: 1'b1, data: mem_fn(ia)});
        end
        if (!rst_ni || !(ir && !eg)) m_cnt = 0;
        else if (m_cnt < 255) m_cnt++;
        m_warn = rst_ni && (m_cnt >= 16);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        // reset state
        idle();
        idle();
        rst_ni = 1'b1;
        idle();

        // fetch only
        cyc(1'b1, 32'h1a11_0800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();

        // device write
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'hf, 32'hdead_beef, 32'h1a11_0100);
        idle();

        // conflict for three cycles, then device drops
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h1a11_0804, 1'b1, 1'b0, 4'hf, 32'h0, 32'h1a11_0200);
        cyc(1'b1, 32'h1a11_0804, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();

        // interleave dev, instr, dev
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'hf, 32'h0, 32'h1a11_0300);
        cyc(1'b1, 32'h1a11_0808, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h0, 32'h1a11_0304);
        idle();
        idle();

        // starvation: warn at 16, saturate at 255
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 32'h1a11_080c, 1'b1, 1'b0, 4'hf, 32'h0, 32'h1a11_0400);
        cyc(1'b1, 32'h1a11_080c, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();

        // reset while a fetch response is in flight
        cyc(1'b1, 32'h1a11_0810, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b0;
        q.delete();
        m_cnt = 0;
        m_warn = 1'b0;
        cyc(1'b1, 32'h1a11_0810, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        rst_ni = 1'b1;
        cyc(1'b1, 32'h1a11_0814, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
